spi_mem_loader: RTL and testbench

- SPI slave, mode 0 (CPOL=0, CPHA=0), that decodes 3-byte frames from an external host.
- Turns each frame into a read or write on the SPI-side port of the memory block, so the host can load the program ROM and read it back.
- Sits between the top-level SPI pins and that memory port.
- All SPI inputs are oversampled in the system clock domain; there is no SCLK clock domain.

---
 rtl/spi_mem_pkg.sv | 29 ++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/spi_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the SPI memory loader: frame commands,
// frame-decoder states and the supported clock-to-SCLK ratio.
package spi_mem_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   // System clock must run at least this many times faster than SCLK.
   localparam int unsigned MIN_CLK_PER_SCLK = 8;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DATA,
      WRITE,
      DONE,
      IGNORE
   } state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous pin, with registered one-clock
// rise and fall pulses derived from the synchronised level.
module sync_edge_detect #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q, rise_q, fall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         rise_q <= sync_q & ~prev_q;
         fall_q <= ~sync_q & prev_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_mem_loader.sv
// Mode-0 SPI slave, oversampled in the system clock domain, that turns
// 3-field command/address/data frames into reads and writes on a memory port.
module spi_mem_loader
   import spi_mem_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = 8,
   parameter int unsigned MEM_DATA_WIDTH = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      spi_sclk,
   input  logic                      spi_cs_n,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   output logic [MEM_ADDR_WIDTH-1:0] address_spi_inf,
   output logic [MEM_DATA_WIDTH-1:0] data_in_spi_inf,
   output logic                      rnw_spi_inf,
   input  logic [MEM_DATA_WIDTH-1:0] data_out_spi_inf,
   output logic                      busy
);

   localparam int unsigned RX_W  = max3(8, MEM_ADDR_WIDTH, MEM_DATA_WIDTH);
   localparam int unsigned CNT_W = $clog2(RX_W);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic cs_n_sync, cs_rise, cs_fall;
   logic mosi_meta_q, mosi_sync_q;

   sync_edge_detect #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk_i (clock),
      .rst_ni(reset_n),
      .async_i(spi_sclk),
      .sync_o(sclk_sync),
      .rise_o(sclk_rise),
      .fall_o(sclk_fall)
   );

   sync_edge_detect #(.RST_VAL(1'b1)) u_cs_sync (
      .clk_i (clock),
      .rst_ni(reset_n),
      .async_i(spi_cs_n),
      .sync_o(cs_n_sync),
      .rise_o(cs_rise),
      .fall_o(cs_fall)
   );

   logic unused_sync;
   assign unused_sync = sclk_sync ^ cs_rise;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         mosi_meta_q <= spi_mosi;
         mosi_sync_q <= mosi_meta_q;
      end
   end

   state_e                    state_q;
   logic [CNT_W-1:0]          bit_cnt_q;
   logic [RX_W-2:0]           rx_q;
   logic [RX_W-1:0]           rx_nxt;
   logic [MEM_DATA_WIDTH-2:0] tx_q;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [MEM_DATA_WIDTH-1:0] wdata_q;
   logic                      rnw_q, miso_q, busy_q;
   logic                      is_read_q, rise_seen_q, ld1_q, ld2_q;

   assign rx_nxt = {rx_q, mosi_sync_q};

   // tx_q holds only the bits still to come; the bit on the wire lives in miso_q.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_q        <= '0;
         tx_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rnw_q       <= 1'b1;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         is_read_q   <= 1'b0;
         rise_seen_q <= 1'b0;
         ld1_q       <= 1'b0;
         ld2_q       <= 1'b0;
      end else begin
         ld1_q <= 1'b0;
         ld2_q <= ld1_q;
         if (cs_n_sync && state_q != IDLE && state_q != WRITE) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            rise_seen_q <= 1'b0;
            ld2_q       <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (cs_fall) begin
                     state_q     <= CMD;
                     busy_q      <= 1'b1;
                     bit_cnt_q   <= '0;
                     rise_seen_q <= 1'b0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     rx_q <= rx_nxt[RX_W-2:0];
                     if (bit_cnt_q == CNT_W'(7)) begin
                        bit_cnt_q <= '0;
                        if (rx_nxt[7:0] == CMD_READ || rx_nxt[7:0] == CMD_WRITE) begin
                           state_q   <= ADDR;
                           is_read_q <= (rx_nxt[7:0] == CMD_READ);
                        end else begin
                           state_q <= IGNORE;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
               ADDR: begin
                  if (sclk_rise) begin
                     rx_q <= rx_nxt[RX_W-2:0];
                     if (bit_cnt_q == CNT_W'(MEM_ADDR_WIDTH - 1)) begin
                        bit_cnt_q   <= '0;
                        addr_q      <= rx_nxt[MEM_ADDR_WIDTH-1:0];
                        rise_seen_q <= 1'b0;
                        ld1_q       <= is_read_q;
                        state_q     <= DATA;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end
               end
               DATA: begin
                  if (sclk_rise) begin
                     rx_q        <= rx_nxt[RX_W-2:0];
                     rise_seen_q <= 1'b1;
                     if (bit_cnt_q == CNT_W'(MEM_DATA_WIDTH - 1)) begin
                        bit_cnt_q <= '0;
                        miso_q    <= 1'b0;
                        if (is_read_q) begin
                           state_q <= DONE;
                        end else begin
                           wdata_q <= rx_nxt[MEM_DATA_WIDTH-1:0];
                           rnw_q   <= 1'b0;
                           state_q <= WRITE;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                     end
                  end else if (ld2_q && is_read_q) begin
                     // Memory data is valid two clocks after the address register updates.
                     miso_q <= data_out_spi_inf[MEM_DATA_WIDTH-1];
                     tx_q   <= data_out_spi_inf[MEM_DATA_WIDTH-2:0];
                  end else if (sclk_fall && is_read_q && rise_seen_q) begin
                     miso_q <= tx_q[MEM_DATA_WIDTH-2];
                     tx_q   <= {tx_q[MEM_DATA_WIDTH-3:0], 1'b0};
                  end
               end
               WRITE: begin
                  rnw_q <= 1'b1;
                  if (cs_n_sync) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign spi_miso        = miso_q;
   assign address_spi_inf = addr_q;
   assign data_in_spi_inf = wdata_q;
   assign rnw_spi_inf     = rnw_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Randomised self-checking bench: an SPI host model drives frames while a
// reference memory array predicts the write log and every read-back byte.
module tb_spi_mem_loader;

   localparam logic [7:0] C_WR = 8'h02;
   localparam logic [7:0] C_RD = 8'h03;

   logic       clock, reset_n, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
   logic [7:0] address_spi_inf, data_in_spi_inf, data_out_spi_inf;
   logic       rnw_spi_inf, busy;

   int tests_run, tests_failed;

   logic [7:0]  mem_model [256];
   logic [7:0]  ref_mem   [256];
   logic [7:0]  written_addrs [$];
   logic [15:0] wq [$];
   logic [7:0]  exp_addr, exp_data;

   spi_mem_loader #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .spi_sclk        (spi_sclk),
      .spi_cs_n        (spi_cs_n),
      .spi_mosi        (spi_mosi),
      .spi_miso        (spi_miso),
      .address_spi_inf (address_spi_inf),
      .data_in_spi_inf (data_in_spi_inf),
      .rnw_spi_inf     (rnw_spi_inf),
      .data_out_spi_inf(data_out_spi_inf),
      .busy            (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous memory: writes while rnw is low, read data one clock after the address.
   always @(posedge clock) begin
      if (rnw_spi_inf === 1'b0) mem_model[address_spi_inf] <= data_in_spi_inf;
      data_out_spi_inf <= mem_model[address_spi_inf];
   end

   // Every clock with rnw low is logged, so a two-clock pulse shows up as two entries.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && rnw_spi_inf === 1'b0) wq.push_back({address_spi_inf, data_in_spi_inf});
   end

   task automatic spi_frame(input logic [23:0] tx, input int nbits, input int half,
                            output logic [23:0] rx, output logic busy_mid);
      rx = '0;
      busy_mid = 1'b0;
      @(negedge clock);
      spi_cs_n = 1'b0;
      spi_mosi = tx[23];
      repeat (half) @(negedge clock);
      for (int i = 0; i < nbits; i++) begin
         rx[23-i] = spi_miso;
         if (i == 12) busy_mid = busy;
         spi_sclk = 1'b1;
         repeat (half) @(negedge clock);
         spi_sclk = 1'b0;
         if (i < 23) spi_mosi = tx[22-i];
         repeat (half) @(negedge clock);
      end
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (4 * half) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         spi_sclk = i[0];
         spi_cs_n = i[1];
         spi_mosi = i[2];
      end
      tests_run++;
      if ({rnw_spi_inf, address_spi_inf, data_in_spi_inf, spi_miso, busy} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_hold: rnw=%b addr=%h data=%h miso=%b busy=%b, want rnw=1 addr=00 data=00 miso=0 busy=0",
                  rnw_spi_inf, address_spi_inf, data_in_spi_inf, spi_miso, busy);
      end
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (4) @(negedge clock);
      reset_n = 1'b1;
      repeat (8) @(negedge clock);
      tests_run++;
      if ({rnw_spi_inf, address_spi_inf, data_in_spi_inf, spi_miso, busy} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_release: rnw=%b addr=%h data=%h miso=%b busy=%b, want 1/00/00/0/0",
                  rnw_spi_inf, address_spi_inf, data_in_spi_inf, spi_miso, busy);
      end
      exp_addr = 8'h00;
      exp_data = 8'h00;
      wq.delete();
   endtask

   task automatic test_write(input logic [7:0] a, input logic [7:0] d, input int half);
      logic [23:0] rx;
      logic        bm;
      wq.delete();
      spi_frame({C_WR, a, d}, 24, half, rx, bm);
      tests_run++;
      if (wq.size() != 1) begin
         tests_failed++;
         $display("FAIL write_pulse_count: got %0d low clocks, want 1 (addr %h data %h)", wq.size(), a, d);
      end else begin
         tests_run++;
         if (wq[0] !== {a, d}) begin
            tests_failed++;
            $display("FAIL write_pulse_value: got addr %h data %h, want addr %h data %h", wq[0][15:8], wq[0][7:0], a, d);
         end
      end
      exp_addr = a;
      exp_data = d;
      tests_run++;
      if (bm !== 1'b1) begin
         tests_failed++;
         $display("FAIL write_busy_mid: got %b, want 1", bm);
      end
      tests_run++;
      if ({busy, rnw_spi_inf, address_spi_inf, data_in_spi_inf} !== {1'b0, 1'b1, exp_addr, exp_data}) begin
         tests_failed++;
         $display("FAIL write_after: busy=%b rnw=%b addr=%h data=%h, want 0/1/%h/%h",
                  busy, rnw_spi_inf, address_spi_inf, data_in_spi_inf, exp_addr, exp_data);
      end
      if (ref_mem[a] === 8'hxx) written_addrs.push_back(a);
      ref_mem[a] = d;
   endtask

   task automatic test_read(input logic [7:0] a, input int half);
      logic [23:0] rx;
      logic        bm;
      logic [7:0]  dummy;
      dummy = 8'($urandom);
      wq.delete();
      spi_frame({C_RD, a, dummy}, 24, half, rx, bm);
      exp_addr = a;
      tests_run++;
      if (rx !== {16'h0000, ref_mem[a]}) begin
         tests_failed++;
         $display("FAIL read_miso: addr %h got miso bits %h, want %h", a, rx, {16'h0000, ref_mem[a]});
      end
      tests_run++;
      if (wq.size() != 0) begin
         tests_failed++;
         $display("FAIL read_no_write: got %0d write clocks, want 0", wq.size());
      end
      tests_run++;
      if ({busy, rnw_spi_inf, address_spi_inf, data_in_spi_inf} !== {1'b0, 1'b1, exp_addr, exp_data}) begin
         tests_failed++;
         $display("FAIL read_after: busy=%b rnw=%b addr=%h data=%h, want 0/1/%h/%h",
                  busy, rnw_spi_inf, address_spi_inf, data_in_spi_inf, exp_addr, exp_data);
      end
   endtask

   task automatic test_abort();
      logic [23:0] rx;
      logic        bm;
      wq.delete();
      spi_frame({C_WR, 8'h40, 8'($urandom)}, 20, 4, rx, bm);
      exp_addr = 8'h40;
      tests_run++;
      if (wq.size() != 0) begin
         tests_failed++;
         $display("FAIL abort_no_write: got %0d write clocks, want 0", wq.size());
      end
      tests_run++;
      if ({busy, spi_miso, address_spi_inf, data_in_spi_inf} !== {1'b0, 1'b0, exp_addr, exp_data}) begin
         tests_failed++;
         $display("FAIL abort_state: busy=%b miso=%b addr=%h data=%h, want 0/0/%h/%h",
                  busy, spi_miso, address_spi_inf, data_in_spi_inf, exp_addr, exp_data);
      end
      test_write(8'h41, 8'h99, 4);
      test_read(8'h41, 4);
   endtask

   task automatic test_invalid(input logic [7:0] cmd, input int half);
      logic [23:0] rx;
      logic        bm;
      wq.delete();
      spi_frame({cmd, 16'($urandom)}, 24, half, rx, bm);
      tests_run++;
      if (rx !== 24'h0) begin
         tests_failed++;
         $display("FAIL invalid_miso: cmd %h got miso bits %h, want 000000", cmd, rx);
      end
      tests_run++;
      if (wq.size() != 0 || address_spi_inf !== exp_addr || data_in_spi_inf !== exp_data) begin
         tests_failed++;
         $display("FAIL invalid_quiet: cmd %h writes=%0d addr=%h data=%h, want 0 writes addr=%h data=%h",
                  cmd, wq.size(), address_spi_inf, data_in_spi_inf, exp_addr, exp_data);
      end
   endtask

   task automatic test_back_to_back();
      test_write(8'h7F, 8'hFF, 4);
      test_read(8'h7F, 4);
      test_write(8'h15, 8'hA7, 8);
      test_read(8'h15, 8);
   endtask

   task automatic test_random();
      logic [7:0] cmd;
      int         op, half;
      for (int n = 0; n < 24; n++) begin
         op   = int'($urandom_range(0, 2));
         half = ($urandom_range(0, 1) == 0) ? 4 : 8;
         if (op == 0 || written_addrs.size() == 0) begin
            test_write(8'($urandom), 8'($urandom), half);
         end else if (op == 1) begin
            test_read(written_addrs[$urandom_range(0, written_addrs.size() - 1)], half);
         end else begin
            cmd = 8'($urandom);
            if (cmd == C_WR || cmd == C_RD) cmd = 8'hA5;
            test_invalid(cmd, half);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n  = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'hxx;
      test_reset();
      test_write(8'h15, 8'hA7, 4);
      test_write(8'h22, 8'h3C, 4);
      test_read(8'h22, 4);
      test_abort();
      test_invalid(8'h55, 4);
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
